// File: rtl/tree_up_concentrator_pkg.sv
// Shared types, defaults and helpers for the tree up-link concentrator.
// Imported by the concentrator top and its per-VC FIFO.
package tree_up_concentrator_pkg;

  localparam int C_DEF    = 4;
  localparam int V_DEF    = 2;
  localparam int B_DEF    = 4;
  localparam int BD_DEF   = 4;
  localparam int FPAY_DEF = 32;

  typedef struct packed {
    logic                hdr;
    logic                tail;
    logic [V_DEF-1:0]    vc;
    logic [FPAY_DEF-1:0] dat;
  } flit_t;

  // Ceiling log2, never below 1 so it is always a usable index width.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic logic [3:0] oh2bin(input logic [15:0] oh);
    logic [3:0] b;
    b = '0;
    for (int k = 0; k < 16; k++)
      if (oh[k]) b = b | 4'(k);
    return b;
  endfunction

endpackage

// File: rtl/tree_conc_fifo.sv
// Single-VC flit FIFO, depth B (power of two); writes while full are dropped.
// Head word is presented combinationally on dout_o.
module tree_conc_fifo
  import tree_up_concentrator_pkg::*;
#(
  parameter int W = 34,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] dout_o
);

  localparam int AW = log2(B);

  logic [AW:0]  wp_q, rp_q;
  logic [W-1:0] mem_q [B];
  logic         wr_en, rd_en;

  // Extra pointer bit separates full from empty.
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_o = (wp_q == rp_q);
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + (AW+1)'(1);
      if (rd_en) rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/tree_up_concentrator.sv
// Merges C child up-links onto one credit-flow-controlled parent link.
// Wormhole VC locking, round-robin over inputs, registered output.
module tree_up_concentrator
  import tree_up_concentrator_pkg::*;
#(
  parameter int C      = C_DEF,
  parameter int V      = V_DEF,
  parameter int B      = B_DEF,
  parameter int B_DOWN = BD_DEF,
  parameter int Fpay   = FPAY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [C-1:0]      in_flit_wr,
  input  logic [C-1:0]      in_flit_hdr,
  input  logic [C-1:0]      in_flit_tail,
  input  logic [C*V-1:0]    in_flit_vc,
  input  logic [C*Fpay-1:0] in_flit_dat,
  output logic [C*V-1:0]    in_credit_out,
  output logic              out_flit_wr,
  output logic              out_flit_hdr,
  output logic              out_flit_tail,
  output logic [V-1:0]      out_flit_vc,
  output logic [Fpay-1:0]   out_flit_dat,
  input  logic [V-1:0]      out_credit_in,
  output logic [V-1:0]      out_vc_busy
);

  localparam int IW = log2(C);
  localparam int VW = log2(V);
  localparam int CW = log2(B_DOWN) + 1;

  typedef struct packed {
    logic            hdr;
    logic            tail;
    logic [Fpay-1:0] dat;
  } word_t;

  word_t                head [C][V];
  logic [C-1:0][V-1:0]  emp, full, push, pop, elig;

  logic [V-1:0]    busy_q, busy_d;
  logic [IW-1:0]   own_q  [V];
  logic [IW-1:0]   own_d  [V];
  logic [CW-1:0]   cred_q [V];
  logic [CW-1:0]   cred_d [V];
  logic [IW-1:0]   rr_q, rr_d;

  logic            gnt;
  logic [IW-1:0]   gi;
  logic [VW-1:0]   gv;
  word_t           gw;
  logic [V-1:0]    gvc, sent;

  logic            wr_q, hdr_q, tail_q;
  logic [V-1:0]    vc_q;
  logic [Fpay-1:0] dat_q;
  logic [C*V-1:0]  cout_q;

  for (genvar i = 0; i < C; i++) begin : g_in
    for (genvar v = 0; v < V; v++) begin : g_vc
      word_t w_in, w_out;
      assign push[i][v] = in_flit_wr[i] & in_flit_vc[i*V+v];
      assign w_in.hdr   = in_flit_hdr[i];
      assign w_in.tail  = in_flit_tail[i];
      assign w_in.dat   = in_flit_dat[i*Fpay +: Fpay];
      tree_conc_fifo #(
        .W (Fpay + 2),
        .B (B)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_i    (push[i][v]),
        .rd_i    (pop[i][v]),
        .din_i   (w_in),
        .full_o  (full[i][v]),
        .empty_o (emp[i][v]),
        .dout_o  (w_out)
      );
      assign head[i][v] = w_out;
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < C; i++)
      for (int v = 0; v < V; v++)
        elig[i][v] = !emp[i][v] && (cred_q[v] != '0) &&
                     (busy_q[v] ? (own_q[v] == IW'(i))
                                : head[i][v].hdr);
  end

  // Round-robin from rr_q; within an input the lowest VC wins.
  always_comb begin
    int idx;
    gnt = 1'b0;
    gi  = '0;
    gv  = '0;
    for (int k = 0; k < C; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= C) idx = idx - C;
      for (int v = 0; v < V; v++) begin
        if (!gnt && elig[idx][v]) begin
          gnt = 1'b1;
          gi  = IW'(idx);
          gv  = VW'(v);
        end
      end
    end
  end

  always_comb begin
    pop  = '0;
    gvc  = '0;
    gw   = head[gi][gv];
    if (gnt) begin
      pop[gi][gv] = 1'b1;
      gvc[gv]     = 1'b1;
    end
    sent = gvc;
  end

  always_comb begin
    busy_d = busy_q;
    own_d  = own_q;
    rr_d   = rr_q;
    if (gnt && gw.tail) begin
      busy_d[gv] = 1'b0;
      rr_d = (gi == IW'(C-1)) ? '0 : gi + IW'(1);
    end else if (gnt && gw.hdr) begin
      busy_d[gv] = 1'b1;
      own_d[gv]  = gi;
    end
    for (int v = 0; v < V; v++) begin
      cred_d[v] = cred_q[v];
      if (sent[v] && !out_credit_in[v])
        cred_d[v] = cred_q[v] - CW'(1);
      else if (out_credit_in[v] && !sent[v] &&
               cred_q[v] != CW'(B_DOWN))
        cred_d[v] = cred_q[v] + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= 1'b0;
      hdr_q  <= 1'b0;
      tail_q <= 1'b0;
      vc_q   <= '0;
      dat_q  <= '0;
      cout_q <= '0;
      busy_q <= '0;
      rr_q   <= '0;
      for (int v = 0; v < V; v++) begin
        own_q[v]  <= '0;
        cred_q[v] <= CW'(B_DOWN);
      end
    end else begin
      wr_q   <= gnt;
      hdr_q  <= gnt & gw.hdr;
      tail_q <= gnt & gw.tail;
      vc_q   <= gvc;
      dat_q  <= gnt ? gw.dat : '0;
      cout_q <= pop;
      busy_q <= busy_d;
      rr_q   <= rr_d;
      own_q  <= own_d;
      cred_q <= cred_d;
    end
  end

  assign out_flit_wr   = wr_q;
  assign out_flit_hdr  = hdr_q;
  assign out_flit_tail = tail_q;
  assign out_flit_vc   = vc_q;
  assign out_flit_dat  = dat_q;
  assign in_credit_out = cout_q;
  assign out_vc_busy   = busy_q;

  a_no_fifo_ovf: assert property (
    @(posedge clk) disable iff (!reset) !(|(push & full)));

  for (genvar v = 0; v < V; v++) begin : g_ca
    a_no_cred_ovf: assert property (
      @(posedge clk) disable iff (!reset)
      !(out_credit_in[v] && !sent[v] &&
        cred_q[v] == CW'(B_DOWN)));
  end

endmodule

// File: tb/tb_tree_up_concentrator.sv
// Directed bench for tree_up_concentrator with a queue-based
// reference model checked after every clock.
module tb_tree_up_concentrator;

  localparam int C  = 4;
  localparam int V  = 2;
  localparam int B  = 4;
  localparam int BD = 4;
  localparam int FP = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [C-1:0]    in_flit_wr, in_flit_hdr, in_flit_tail;
  logic [C*V-1:0]  in_flit_vc, in_credit_out;
  logic [C*FP-1:0] in_flit_dat;
  logic            out_flit_wr, out_flit_hdr, out_flit_tail;
  logic [V-1:0]    out_flit_vc, out_credit_in, out_vc_busy;
  logic [FP-1:0]   out_flit_dat;

  always #5 clk = ~clk;

  tree_up_concentrator #(
    .C(C), .V(V), .B(B), .B_DOWN(BD), .Fpay(FP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_flit_wr    (in_flit_wr),
    .in_flit_hdr   (in_flit_hdr),
    .in_flit_tail  (in_flit_tail),
    .in_flit_vc    (in_flit_vc),
    .in_flit_dat   (in_flit_dat),
    .in_credit_out (in_credit_out),
    .out_flit_wr   (out_flit_wr),
    .out_flit_hdr  (out_flit_hdr),
    .out_flit_tail (out_flit_tail),
    .out_flit_vc   (out_flit_vc),
    .out_flit_dat  (out_flit_dat),
    .out_credit_in (out_credit_in),
    .out_vc_busy   (out_vc_busy)
  );

  typedef struct {
    bit            hdr;
    bit            tail;
    logic [FP-1:0] dat;
  } mf_t;

  typedef struct {
    logic [V-1:0]  vc;
    logic [FP-1:0] dat;
  } ob_t;

  mf_t  mq [C*V][$];
  int   m_own [V];
  int   m_cred [V];
  int   m_rr;

  bit             e_wr, e_hdr, e_tail;
  logic [V-1:0]   e_vc, e_busy;
  logic [FP-1:0]  e_dat;
  logic [C*V-1:0] e_cout;

  int   nvec = 0;
  int   nerr = 0;
  bit   auto_cred;
  logic [V-1:0] man_cin;
  ob_t  obs [$];

  logic [FP-1:0] exp2 [6] = '{32'h100, 32'h101, 32'h102,
                              32'h200, 32'h201, 32'h202};

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < C*V; k++) mq[k].delete();
    for (int v = 0; v < V; v++) begin
      m_own[v]  = -1;
      m_cred[v] = BD;
    end
    m_rr = 0;
    e_wr = 0; e_hdr = 0; e_tail = 0;
    e_vc = '0; e_dat = '0; e_cout = '0; e_busy = '0;
  endtask

  // Advance the model across one rising edge using current inputs.
  task automatic model_step();
    int  pre [C*V];
    int  gi, gv, i;
    bit  found, s, c;
    mf_t f;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < C*V; k++) pre[k] = mq[k].size();
    found = 0; gi = 0; gv = 0;
    for (int k = 0; k < C; k++) begin
      i = (m_rr + k) % C;
      for (int v = 0; v < V; v++)
        if (!found && mq[i*V+v].size() > 0 && m_cred[v] > 0 &&
            (m_own[v] == i ||
             (m_own[v] < 0 && mq[i*V+v][0].hdr))) begin
          found = 1; gi = i; gv = v;
        end
    end
    e_wr = found; e_hdr = 0; e_tail = 0;
    e_vc = '0; e_dat = '0; e_cout = '0;
    if (found) begin
      f = mq[gi*V+gv].pop_front();
      e_hdr = f.hdr; e_tail = f.tail; e_dat = f.dat;
      e_vc[gv] = 1'b1;
      e_cout[gi*V+gv] = 1'b1;
      if (f.tail) begin
        m_own[gv] = -1;
        m_rr = (gi + 1) % C;
      end else if (f.hdr) m_own[gv] = gi;
    end
    for (int v = 0; v < V; v++) begin
      s = found && gv == v;
      c = out_credit_in[v];
      if (s && !c) m_cred[v]--;
      else if (c && !s && m_cred[v] < BD) m_cred[v]++;
    end
    for (int k = 0; k < C; k++)
      if (in_flit_wr[k])
        for (int v = 0; v < V; v++)
          if (in_flit_vc[k*V+v] && pre[k*V+v] < B) begin
            f.hdr = in_flit_hdr[k];
            f.tail = in_flit_tail[k];
            f.dat = in_flit_dat[k*FP +: FP];
            mq[k*V+v].push_back(f);
          end
    for (int v = 0; v < V; v++) e_busy[v] = (m_own[v] >= 0);
  endtask

  task automatic step();
    out_credit_in = man_cin |
      ((auto_cred && out_flit_wr) ? out_flit_vc : '0);
    model_step();
    @(posedge clk);
    #1;
    chk("out_wr", out_flit_wr, e_wr);
    if (e_wr) begin
      chk("out_hdr", out_flit_hdr, e_hdr);
      chk("out_tail", out_flit_tail, e_tail);
      chk("out_vc", out_flit_vc, e_vc);
      chk("out_dat", out_flit_dat, e_dat);
    end
    chk("cred_out", in_credit_out, e_cout);
    chk("vc_busy", out_vc_busy, e_busy);
    if (out_flit_wr) obs.push_back('{out_flit_vc, out_flit_dat});
  endtask

  task automatic idle();
    in_flit_wr = '0; in_flit_hdr = '0; in_flit_tail = '0;
    in_flit_vc = '0; in_flit_dat = '0; man_cin = '0;
  endtask

  task automatic put(int i, int v, bit h, bit t,
                     logic [FP-1:0] d);
    logic [V-1:0] oh;
    oh = '0;
    oh[v] = 1'b1;
    in_flit_wr[i] = 1'b1;
    in_flit_hdr[i] = h;
    in_flit_tail[i] = t;
    in_flit_vc[i*V +: V] = oh;
    in_flit_dat[i*FP +: FP] = d;
  endtask

  task automatic idles(int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, sw;
    idle();
    out_credit_in = '0;
    auto_cred = 1;
    model_reset();
    #12;
    chk("rst_wr", out_flit_wr, 0);
    chk("rst_busy", out_vc_busy, 0);
    chk("rst_cout", in_credit_out, 0);
    reset = 1'b1;

    // single-flit packet, input 2, VC0
    idle(); put(2, 0, 1, 1, 32'hA5); step();
    idle(); step();
    chk("t1_wr", out_flit_wr, 1);
    chk("t1_dat", out_flit_dat, 32'hA5);
    chk("t1_vc", out_flit_vc, 2'b01);
    chk("t1_cret", in_credit_out, 8'h10);
    idles(4);

    // wormhole lock on VC1
    obs.delete();
    idle(); put(0, 1, 1, 0, 'h100); put(1, 1, 1, 0, 'h200); step();
    idle(); put(0, 1, 0, 0, 'h101); put(1, 1, 0, 0, 'h201); step();
    idle(); put(0, 1, 0, 1, 'h102); put(1, 1, 0, 1, 'h202); step();
    idles(10);
    chk("t2_cnt", obs.size(), 6);
    for (int k = 0; k < 6 && k < obs.size(); k++) begin
      chk("t2_seq", obs[k].dat, exp2[k]);
      chk("t2_vc", obs[k].vc, 2'b10);
    end

    // VC parallelism: input 0 paced on VC0, input 1 on VC1
    obs.delete();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c % 2 == 0) put(0, 0, c == 0, c == 6, 'h300 + c/2);
      if (c < 4) put(1, 1, c == 0, c == 3, 'h400 + c);
      step();
    end
    idles(8);
    n0 = 0; n1 = 0; sw = 0;
    for (int k = 0; k < obs.size(); k++) begin
      if (obs[k].vc == 2'b01) begin
        chk("t3_vc0", obs[k].dat, 'h300 + n0); n0++;
      end else begin
        chk("t3_vc1", obs[k].dat, 'h400 + n1); n1++;
      end
      if (k > 0 && obs[k].vc != obs[k-1].vc) sw++;
    end
    chk("t3_n0", n0, 4);
    chk("t3_n1", n1, 4);
    chk("t3_ilv", sw >= 2, 1);

    // credit stall
    auto_cred = 0;
    obs.delete();
    for (int c = 0; c < 6; c++) begin
      idle(); put(3, 0, c == 0, c == 5, 'h500 + c); step();
    end
    idles(6);
    chk("t4_stall", obs.size(), 4);
    idle(); man_cin = 2'b01; step();
    idle(); step();
    idle(); man_cin = 2'b01; step();
    idles(4);
    chk("t4_release", obs.size(), 6);
    for (int k = 0; k < 4; k++) begin
      idle(); man_cin = 2'b01; step();
      idle(); step();
    end

    // credit return in the same cycle as a send
    obs.delete();
    idle(); put(1, 0, 1, 1, 'h600); step();
    idle(); step();
    idle(); put(1, 0, 1, 1, 'h601); step();
    idle(); man_cin = 2'b01; step();
    for (int k = 0; k < 4; k++) begin
      idle(); put(1, 0, 1, 1, 'h602 + k); step();
    end
    idles(6);
    chk("t5_sent", obs.size(), 5);
    for (int k = 0; k < 5; k++) begin
      idle(); man_cin = 2'b01; step();
      idle(); step();
    end
    auto_cred = 1;
    idles(2);

    // asynchronous reset in the middle of a packet
    idle(); put(0, 1, 1, 0, 'h700); step();
    idle(); put(0, 1, 0, 0, 'h701); step();
    chk("t6_busy_pre", out_vc_busy, 2'b10);
    idle();
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_wr", out_flit_wr, 0);
    chk("t6_rst_busy", out_vc_busy, 0);
    chk("t6_rst_dat", out_flit_dat, 0);
    chk("t6_rst_cout", in_credit_out, 0);
    step();
    #2 reset = 1'b1;
    idle(); put(2, 1, 1, 0, 'h800); step();
    idle(); put(2, 1, 0, 1, 'h801); step();
    chk("t6_new_dat", out_flit_dat, 'h800);
    chk("t6_new_busy", out_vc_busy, 2'b10);
    idles(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
